debouncer_bank_irq: RTL and testbench

//  Parametrised bank of NR_OF_CHANNELS debouncers for active-low push-buttons/switches.
//  Per channel: 2-flop synchroniser, integrating filter clocked by a shared scanTick,
//  and sticky press/release interrupt flags with per-bit enable and clear.

---
 rtl/debouncer_bank_irq.sv | 133 +++++++++++++
 tb/tb_debouncer_bank_irq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/debouncer_bank_irq.sv
// Bank of active-low button debouncers with sticky press/release interrupt flags.
// Define LONG_PRESS_IRQ_EN to add per-channel long-press detection and flags.
module debouncer_bank_irq #(
   parameter int NR_OF_CHANNELS   = 8,
   parameter int FILTER_DEPTH     = 4,
   parameter int LONG_PRESS_TICKS = 500
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NR_OF_CHANNELS-1:0] nButtonIn,
   input  logic                      scanTick,
   input  logic [NR_OF_CHANNELS-1:0] enablePressIrq,
   input  logic [NR_OF_CHANNELS-1:0] enableReleaseIrq,
   input  logic [NR_OF_CHANNELS-1:0] clearPressIrq,
   input  logic [NR_OF_CHANNELS-1:0] clearReleaseIrq,
   output logic [NR_OF_CHANNELS-1:0] pressIrq,
   output logic [NR_OF_CHANNELS-1:0] releaseIrq,
   output logic [NR_OF_CHANNELS-1:0] currentState,
`ifdef LONG_PRESS_IRQ_EN
   input  logic [NR_OF_CHANNELS-1:0] enableLongPressIrq,
   input  logic [NR_OF_CHANNELS-1:0] clearLongPressIrq,
   output logic [NR_OF_CHANNELS-1:0] longPressIrq,
`endif
   output logic                      irq
);

   localparam int N  = NR_OF_CHANNELS;
   localparam int CW = $clog2(FILTER_DEPTH + 1);
   localparam logic [CW-1:0] CMAX = CW'(FILTER_DEPTH - 1);

   logic [N-1:0]  sync1_q, sync2_q;
   logic [N-1:0]  state_q, state_d;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  flip;
   logic [N-1:0]  press_q, press_d;
   logic [N-1:0]  rel_q, rel_d;
   logic [N-1:0]  flags;
   logic          irq_q;

   // Integrating filter: only ticks move the counter, a matching sample resets it.
   always_comb begin
      flip = '0;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (scanTick) begin
            if (sync2_q[i] == state_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CMAX) begin
               flip[i]  = 1'b1;
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign state_d = state_q ^ flip;
   assign press_d = (flip & ~state_q & enablePressIrq)
                  | (press_q & ~clearPressIrq);
   assign rel_d   = (flip & state_q & enableReleaseIrq)
                  | (rel_q & ~clearReleaseIrq);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         irq_q   <= 1'b0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= ~nButtonIn;
         sync2_q <= sync1_q;
         state_q <= state_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         irq_q   <= |flags;
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef LONG_PRESS_IRQ_EN
   localparam int LW = $clog2(LONG_PRESS_TICKS + 1);
   localparam logic [LW-1:0] LMAX = LW'(LONG_PRESS_TICKS);
   localparam logic [LW-1:0] LPRE = LW'(LONG_PRESS_TICKS - 1);

   logic [LW-1:0] hold_q [N];
   logic [LW-1:0] hold_d [N];
   logic [N-1:0]  long_ev;
   logic [N-1:0]  long_q, long_d;

   // Hold counter saturates at the threshold so each press fires once.
   always_comb begin
      long_ev = '0;
      for (int i = 0; i < N; i++) begin
         hold_d[i] = hold_q[i];
         if (!state_q[i]) begin
            hold_d[i] = '0;
         end else if (scanTick && hold_q[i] != LMAX) begin
            hold_d[i]  = hold_q[i] + LW'(1);
            long_ev[i] = (hold_q[i] == LPRE);
         end
      end
   end

   assign long_d = (long_ev & enableLongPressIrq)
                 | (long_q & ~clearLongPressIrq);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         long_q <= '0;
         for (int i = 0; i < N; i++) hold_q[i] <= '0;
      end else begin
         long_q <= long_d;
         for (int i = 0; i < N; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign longPressIrq = long_q;
   assign flags        = press_q | rel_q | long_q;
`else
   assign flags        = press_q | rel_q;
`endif

   assign pressIrq     = press_q;
   assign releaseIrq   = rel_q;
   assign currentState = state_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_debouncer_bank_irq.sv
// Directed self-checking bench for debouncer_bank_irq (N=8, FILTER_DEPTH=4).
module tb_debouncer_bank_irq;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] nButtonIn;
   logic       scanTick;
   logic [7:0] enablePressIrq, enableReleaseIrq;
   logic [7:0] clearPressIrq, clearReleaseIrq;
   logic [7:0] pressIrq, releaseIrq, currentState;
   logic       irq;
`ifdef LONG_PRESS_IRQ_EN
   logic [7:0] enableLongPressIrq, clearLongPressIrq, longPressIrq;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   debouncer_bank_irq #(
      .NR_OF_CHANNELS(8),
      .FILTER_DEPTH(4),
      .LONG_PRESS_TICKS(5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .nButtonIn(nButtonIn),
      .scanTick(scanTick),
      .enablePressIrq(enablePressIrq),
      .enableReleaseIrq(enableReleaseIrq),
      .clearPressIrq(clearPressIrq),
      .clearReleaseIrq(clearReleaseIrq),
      .pressIrq(pressIrq),
      .releaseIrq(releaseIrq),
      .currentState(currentState),
`ifdef LONG_PRESS_IRQ_EN
      .enableLongPressIrq(enableLongPressIrq),
      .clearLongPressIrq(clearLongPressIrq),
      .longPressIrq(longPressIrq),
`endif
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; inputs change right after a negedge and are released at the next.
   task automatic cyc(input bit t, input logic [7:0] cp, input logic [7:0] cr);
      scanTick        = t;
      clearPressIrq   = cp;
      clearReleaseIrq = cr;
      @(negedge clock);
      scanTick        = 1'b0;
      clearPressIrq   = '0;
      clearReleaseIrq = '0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 8'h00, 8'h00);
   endtask

   task automatic pins(input logic [7:0] v);
      nButtonIn = v;
      cyc(1'b0, 8'h00, 8'h00);
      cyc(1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      reset            = 1'b1;
      nButtonIn        = 8'h00;
      scanTick         = 1'b0;
      enablePressIrq   = 8'hFF;
      enableReleaseIrq = 8'hFF;
      clearPressIrq    = '0;
      clearReleaseIrq  = '0;
`ifdef LONG_PRESS_IRQ_EN
      enableLongPressIrq = 8'h00;
      clearLongPressIrq  = 8'h00;
`endif
      // reset with all buttons held
      repeat (3) @(negedge clock);
      chk("rst_state", 32'(currentState), 32'h00);
      chk("rst_press", 32'(pressIrq), 32'h00);
      chk("rst_rel", 32'(releaseIrq), 32'h00);
      chk("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      pins(8'h00);
      ticks(3);
      chk("rq_state3", 32'(currentState), 32'h00);
      ticks(1);
      chk("rq_state4", 32'(currentState), 32'hFF);
      chk("rq_press", 32'(pressIrq), 32'hFF);
      chk("rq_irq_lag", 32'(irq), 32'h0);
      cyc(1'b0, 8'hFF, 8'h00);
      chk("rq_irq", 32'(irq), 32'h1);
      chk("clr_press", 32'(pressIrq), 32'h00);
      // release everything
      pins(8'hFF);
      ticks(4);
      chk("rel_state", 32'(currentState), 32'h00);
      chk("rel_flags", 32'(releaseIrq), 32'hFF);
      cyc(1'b0, 8'h00, 8'hFF);
      chk("clr_rel", 32'(releaseIrq), 32'h00);
      // glitch of 3 ticks on ch0 is rejected
      pins(8'hFE);
      ticks(3);
      pins(8'hFF);
      ticks(1);
      chk("glitch_state", 32'(currentState), 32'h00);
      chk("glitch_press", 32'(pressIrq), 32'h00);
      pins(8'hFE);
      ticks(3);
      chk("db_state3", 32'(currentState), 32'h00);
      ticks(1);
      chk("db_state4", 32'(currentState), 32'h01);
      chk("db_press", 32'(pressIrq), 32'h01);
      // masked release on ch2
      pins(8'hFA);
      ticks(4);
      chk("m_state", 32'(currentState), 32'h05);
      chk("m_press", 32'(pressIrq), 32'h05);
      enableReleaseIrq = 8'hFB;
      pins(8'hFE);
      ticks(4);
      chk("m_relstate", 32'(currentState), 32'h01);
      chk("m_relflag", 32'(releaseIrq), 32'h00);
      enableReleaseIrq = 8'hFF;
      ticks(4);
      chk("m_noqueue", 32'(releaseIrq), 32'h00);
      // set wins over clear
      cyc(1'b0, 8'hFF, 8'h00);
      chk("c_cleared", 32'(pressIrq), 32'h00);
      pins(8'hFC);
      ticks(3);
      cyc(1'b1, 8'h02, 8'h00);
      chk("c_state", 32'(currentState), 32'h03);
      chk("c_setwins", 32'(pressIrq), 32'h02);
      cyc(1'b0, 8'h02, 8'h00);
      chk("c_clear", 32'(pressIrq), 32'h00);
      chk("c_irq_hold", 32'(irq), 32'h1);
      cyc(1'b0, 8'h00, 8'h00);
      chk("c_irq_fall", 32'(irq), 32'h0);
      // pin activity without scanTick
      for (int i = 0; i < 1000; i++) begin
         nButtonIn = 8'($urandom);
         cyc(1'b0, 8'h00, 8'h00);
      end
      chk("nt_state", 32'(currentState), 32'h03);
      chk("nt_press", 32'(pressIrq), 32'h00);
      chk("nt_rel", 32'(releaseIrq), 32'h00);
      chk("nt_irq", 32'(irq), 32'h0);
      pins(8'hFC);
      ticks(1);
      chk("nt_resume", 32'(currentState), 32'h03);
`ifdef LONG_PRESS_IRQ_EN
      enableLongPressIrq = 8'h08;
      pins(8'hF4);
      ticks(4);
      chk("lp_state", 32'(currentState), 32'h0B);
      ticks(4);
      chk("lp_early", 32'(longPressIrq), 32'h00);
      ticks(1);
      chk("lp_set", 32'(longPressIrq), 32'h08);
      clearLongPressIrq = 8'h08;
      cyc(1'b0, 8'h00, 8'h00);
      clearLongPressIrq = 8'h00;
      chk("lp_clr", 32'(longPressIrq), 32'h00);
      ticks(20);
      chk("lp_once", 32'(longPressIrq), 32'h00);
      pins(8'hFC);
      ticks(4);
      chk("lp_rel", 32'(currentState), 32'h03);
      pins(8'hF4);
      ticks(4);
      ticks(4);
      chk("lp_re_early", 32'(longPressIrq), 32'h00);
      ticks(1);
      chk("lp_re_set", 32'(longPressIrq), 32'h08);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
